// File: rtl/gsram_pkg.sv
// Shared types for the gsram scratchpad tile: request opcodes, FSM states
// and the row-major address helper used by the tile.
package gsram_pkg;

    typedef enum logic [1:0] {
        OP_RD     = 2'b00,
        OP_WR     = 2'b01,
        OP_RD_ROW = 2'b10,
        OP_RD_COL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BURST
    } state_t;

    // Row-major flat word index.
    function automatic int lin_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/gsram_array.sv
// Plain word storage for the tile: one synchronous write port and one
// synchronous read port. The read register only updates when re is high,
// so the tile can hold a stalled beat simply by not reading.
module gsram_array #(
    parameter int DEPTH = 100,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    // NOTE: storage is deliberately not reset; the tile zero-fills it word by word after reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port with enable; rdata holds its value while re is low.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/gsram_tile.sv
// 2D scratchpad tile: valid/ready request port, single and row/column burst
// reads, address range checking and an automatic zero-fill after reset.
module gsram_tile
    import gsram_pkg::*;
#(
    parameter  int ROWS  = 10,
    parameter  int COLS  = 10,
    parameter  int WIDTH = 16,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [RW-1:0]    req_row,
    input  logic [CW-1:0]    req_col,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic             busy
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int MAXN  = (ROWS > COLS) ? ROWS : COLS;
    localparam int IW    = (MAXN > 1) ? $clog2(MAXN) : 1;

    state_t           state;
    op_t              op;
    logic             accept;
    logic             advance;
    logic             row_oor;
    logic             col_oor;
    logic             req_err;

    // Burst context latched at acceptance.
    logic             burst_col;   // 1: column burst, 0: row burst
    logic             burst_err;
    logic [RW-1:0]    burst_row;
    logic [CW-1:0]    burst_cidx;
    logic [IW-1:0]    idx;         // index of the beat currently presented
    logic [AW-1:0]    clr_cnt;
    int               burst_len;
    int               next_idx;

    // Array port signals.
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign op        = op_t'(req_op);
    assign req_ready = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign advance   = rsp_valid && rsp_ready;
    assign row_oor   = int'(req_row) >= ROWS;
    assign col_oor   = int'(req_col) >= COLS;
    assign burst_len = burst_col ? ROWS : COLS;
    assign next_idx  = int'(idx) + 1;

    // Error beats carry zero data; gating on rsp_valid also keeps rsp_data 0 in reset.
    assign rsp_data  = (rsp_valid && !rsp_err) ? rdata : '0;

    // Range check: each opcode only looks at the coordinates it uses.
    always_comb begin
        case (op)
            OP_RD, OP_WR: req_err = row_oor || col_oor;
            OP_RD_ROW:    req_err = row_oor;
            default:      req_err = col_oor;
        endcase
    end

    // Array port steering: clear writes, request writes/reads, burst prefetch of the next beat.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        re    = 1'b0;
        raddr = '0;
        case (state)
            ST_CLEAR: begin
                we    = busy;
                waddr = clr_cnt;
            end
            ST_IDLE: begin
                if (accept && !req_err) begin
                    if (op == OP_WR) begin
                        we    = 1'b1;
                        waddr = AW'(lin_index(int'(req_row), int'(req_col), COLS));
                        wdata = req_wdata;
                    end else begin
                        re    = 1'b1;
                        raddr = AW'(lin_index((op == OP_RD_COL) ? 0 : int'(req_row),
                                              (op == OP_RD_ROW) ? 0 : int'(req_col), COLS));
                    end
                end
            end
            ST_BURST: begin
                if (advance && !rsp_last && !burst_err) begin
                    re    = 1'b1;
                    raddr = burst_col ? AW'(lin_index(next_idx, int'(burst_cidx), COLS))
                                      : AW'(lin_index(int'(burst_row), next_idx, COLS));
                end
            end
            default: ;
        endcase
    end

    // Main FSM: zero-fill, request acceptance, burst sequencing and the response register.
    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            busy       <= 1'b0;
            clr_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_last   <= 1'b0;
            rsp_err    <= 1'b0;
            burst_col  <= 1'b0;
            burst_err  <= 1'b0;
            burst_row  <= '0;
            burst_cidx <= '0;
            idx        <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // First cycle after release arms busy; the following DEPTH cycles write zeros.
                    busy <= 1'b1;
                    if (busy) begin
                        if (int'(clr_cnt) == DEPTH - 1) begin
                            clr_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (advance) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                    if (accept) begin
                        case (op)
                            OP_RD: begin
                                rsp_valid <= 1'b1;
                                rsp_last  <= 1'b1;
                                rsp_err   <= req_err;
                            end
                            OP_RD_ROW, OP_RD_COL: begin
                                rsp_valid  <= 1'b1;
                                rsp_last   <= (((op == OP_RD_COL) ? ROWS : COLS) == 1);
                                rsp_err    <= req_err;
                                burst_col  <= (op == OP_RD_COL);
                                burst_err  <= req_err;
                                burst_row  <= req_row;
                                burst_cidx <= req_col;
                                idx        <= '0;
                                busy       <= 1'b1;
                                state      <= ST_BURST;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BURST: begin
                    if (advance) begin
                        if (rsp_last) begin
                            rsp_valid <= 1'b0;
                            rsp_last  <= 1'b0;
                            rsp_err   <= 1'b0;
                            idx       <= '0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx      <= idx + 1'b1;
                            rsp_last <= (next_idx == burst_len - 1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    gsram_array #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_gsram_tile.sv
// Scoreboard bench for gsram_tile: the driver pushes expected beats computed
// from a 2D array model at acceptance; a negedge monitor pops and compares.
module tb_gsram_tile;
    import gsram_pkg::*;

    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int WIDTH = 16;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [RW-1:0]    req_row = '0;
    logic [CW-1:0]    req_col = '0;
    logic [WIDTH-1:0] req_wdata = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_last;
    logic             rsp_err;
    logic             busy;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             err;
        bit               burst;
        int               due;     // cycle the beat must first appear, -1 = unchecked
    } beat_t;

    beat_t exp_q[$];
    int    mem_m [ROWS][COLS];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    ready_mode = 0;         // 0: always ready, 1: toggle, 2: random

    gsram_tile #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer back-pressure pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ~rsp_ready;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stall stability, then pop-and-compare on every handshake.
    initial begin
        bit               stalled;
        logic [WIDTH-1:0] s_data;
        logic             s_last;
        logic             s_err;
        int               first_seen;
        beat_t            e;
        stalled    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        s_err      = 1'b0;
        first_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_data", 32'(rsp_data), 32'(s_data));
                    check("hold_last", 32'(rsp_last), 32'(s_last));
                    check("hold_err", 32'(rsp_err), 32'(s_err));
                end else if (rsp_valid) begin
                    first_seen = cyc;
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_last", 32'(rsp_last), 32'(e.last));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (e.due >= 0) check("rd_latency", 32'(first_seen), 32'(e.due));
                        if (e.burst) check("req_ready_in_burst", 32'(req_ready), 32'd0);
                    end
                    stalled = 1'b0;
                end else if (rsp_valid) begin
                    stalled = 1'b1;
                    s_data  = rsp_data;
                    s_last  = rsp_last;
                    s_err   = rsp_err;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Reference model: applies writes and queues the beats a read must produce.
    task automatic model(input op_t op, input int row, input int col, input int wdata, input int due);
        beat_t b;
        bit    in_r;
        bit    in_c;
        in_r = (row < ROWS);
        in_c = (col < COLS);
        case (op)
            OP_WR: if (in_r && in_c) mem_m[row][col] = wdata & 16'hFFFF;
            OP_RD: begin
                b.err   = !(in_r && in_c);
                b.data  = b.err ? '0 : WIDTH'(mem_m[row][col]);
                b.last  = 1'b1;
                b.burst = 1'b0;
                b.due   = due;
                exp_q.push_back(b);
            end
            OP_RD_ROW: begin
                for (int c = 0; c < COLS; c++) begin
                    b.err   = !in_r;
                    b.data  = b.err ? '0 : WIDTH'(mem_m[row][c]);
                    b.last  = (c == COLS - 1);
                    b.burst = 1'b1;
                    b.due   = -1;
                    exp_q.push_back(b);
                end
            end
            default: begin
                for (int r = 0; r < ROWS; r++) begin
                    b.err   = !in_c;
                    b.data  = b.err ? '0 : WIDTH'(mem_m[r][col]);
                    b.last  = (r == ROWS - 1);
                    b.burst = 1'b1;
                    b.due   = -1;
                    exp_q.push_back(b);
                end
            end
        endcase
    endtask

    // Present one request (caller is aligned to posedge+1); returns aligned to posedge+1.
    task automatic issue(input op_t op, input int row, input int col, input int wdata);
        int waited;
        bit ok;
        waited    = 0;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_row   = RW'(row);
        req_col   = CW'(col);
        req_wdata = WIDTH'(wdata);
        while (waited < 2000) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (ok) model(op, row, col, wdata, cyc + 1);
        else check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty and the response port to go quiet.
    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || rsp_valid) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 3000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Release reset and measure the zero-fill window.
    task automatic release_and_clear();
        int n_busy;
        int bad_ready;
        n_busy    = 0;
        bad_ready = 0;
        rst_n     = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) begin
                n_busy++;
                if (req_ready) bad_ready++;
            end else if (n_busy > 0) begin
                break;
            end
        end
        check("clear_busy_cycles", 32'(n_busy), 32'd100);
        check("clear_req_ready_low", 32'(bad_ready), 32'd0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem_m[r][c] = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // T1: zero-fill then read a cleared word.
        release_and_clear();
        ready_mode = 0;
        issue(OP_RD, 3, 7, 0);
        drain();

        // T2: write-then-read back-to-back.
        issue(OP_WR, 2, 5, 16'hBEEF);
        issue(OP_RD, 2, 5, 0);
        drain();

        // T3: row burst at full rate.
        for (int c = 0; c < COLS; c++) issue(OP_WR, 4, c, 16'h0400 + c);
        issue(OP_RD_ROW, 4, 0, 0);
        drain();

        // T4: column burst with alternating back-pressure.
        for (int r = 0; r < ROWS; r++) issue(OP_WR, r, 6, 16'h1000 + r);
        ready_mode = 1;
        issue(OP_RD_COL, 0, 6, 0);
        drain();

        // T5: out-of-range write, read and row burst, then sweep every row.
        ready_mode = 0;
        issue(OP_WR, 12, 3, 16'hFFFF);
        issue(OP_RD, 12, 3, 0);
        issue(OP_RD_ROW, 11, 0, 0);
        issue(OP_RD_COL, 0, 13, 0);
        drain();
        ready_mode = 2;
        for (int r = 0; r < ROWS; r++) issue(OP_RD_ROW, r, 0, 0);
        drain();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            issue(op_t'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), int'($urandom_range(0, 16'hFFFF)));
        end
        drain();

        // T6: reset in the middle of a row burst.
        ready_mode = 0;
        issue(OP_WR, 2, 5, 16'h5A5A);
        issue(OP_RD_ROW, 4, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midburst_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midburst_rst_busy", 32'(busy), 32'd0);
        check("midburst_rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        release_and_clear();
        issue(OP_RD, 2, 5, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
